// File: rtl/result_readout_fifo_if.sv
// result_readout_fifo_if: capture/readout bus between datapath, queue and consumer.
// READOUT_STATS_EN adds the max_count peak-occupancy signal.
interface result_readout_fifo_if #(parameter int W = 16, parameter int AW = 2);
  logic load;
  logic [W-1:0] D;
  logic [W-1:0] Q;
  logic valid;
  logic ready;
  logic full;
  logic [AW:0] count;
  logic overflow;
  logic clr_ovf;
`ifdef READOUT_STATS_EN
  logic [AW:0] max_count;
  modport master (output load, D, ready, clr_ovf, input Q, valid, full, count, overflow, max_count);
  modport slave (input load, D, ready, clr_ovf, output Q, valid, full, count, overflow, max_count);
`else
  modport master (output load, D, ready, clr_ovf, input Q, valid, full, count, overflow);
  modport slave (input load, D, ready, clr_ovf, output Q, valid, full, count, overflow);
`endif
endinterface

// File: rtl/result_readout_fifo.sv
// result_readout_fifo: FWFT queue buffering load-strobed result words for a stallable consumer.
// READOUT_STATS_EN adds max_count, the peak occupancy since rst or clr_ovf.
module result_readout_fifo #(
  parameter int W = 16,
  parameter int AW = 2
) (
  input logic clk,
  input logic rst,
  result_readout_fifo_if.slave bus
);
  localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);
  logic [W-1:0] r_mem [2**AW];
  logic [AW-1:0] r_rd, r_wr;
  logic [AW:0] r_count;
  logic r_ovf;
  logic w_pop, w_push;
  assign bus.valid = r_count != '0;
  assign bus.full = r_count == DEPTH;
  assign bus.count = r_count;
  assign bus.overflow = r_ovf;
  assign bus.Q = bus.valid ? r_mem[r_rd] : '0;
  assign w_pop = bus.valid && bus.ready;
  // a full queue still accepts a word when the same edge frees a slot
  assign w_push = bus.load && (!bus.full || w_pop);
  always_ff @(posedge clk)
    if (w_push && !rst) r_mem[r_wr] <= bus.D;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd <= '0;
      r_wr <= '0;
      r_count <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (w_push) r_wr <= r_wr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_ovf <= (bus.load && !w_push) ? 1'b1 : bus.clr_ovf ? 1'b0 : r_ovf;
    end
  end
`ifdef READOUT_STATS_EN
  logic [AW:0] r_max;
  assign bus.max_count = r_max;
  always_ff @(posedge clk)
    r_max <= rst ? '0 : bus.clr_ovf ? r_count : (r_count > r_max) ? r_count : r_max;
`endif
endmodule

// File: doc/result_readout_fifo.md
Name: result_readout_fifo

Overview:
Reader-side companion to the load-enabled result registers in the CORDIC natural-log datapath. It captures each word the datapath presents with a load strobe and buffers it in a small first-word-fall-through queue. The queue drains through a valid/ready handshake to the downstream consumer (bus interface or test harness). It decouples the single-cycle load pulse of the datapath from a consumer that may stall.

Parameters:
W, 16, data word width in bits
AW, 2, address width; queue depth = 2**AW entries (default 4)

Ports:
clk  input  1  system clock
rst  input  1  system reset, synchronous, active-high
load  input  1  write strobe from datapath; D captured on the rising clk edge when high
D  input  W  data word to capture
Q  output  W  head-of-queue word; 0 when empty
valid  output  1  high when Q holds an unread word (queue not empty)
ready  input  1  consumer accepts Q on the rising clk edge when valid && ready
full  output  1  high when count == 2**AW
count  output  AW+1  number of stored words, 0..2**AW
overflow  output  1  sticky; set when a load is dropped
clr_ovf  input  1  clears overflow on the next edge

Behaviour:
- Single clock domain (clk). rst is synchronous and active-high, sampled only on the rising clk edge.
- Reset values: rd/wr pointers = 0, count = 0, valid = 0, full = 0, overflow = 0, Q = 0. Memory contents are don't-care and are not cleared.
- rst overrides every other input in the same cycle, including mid-operation. Any queued words are discarded.
- pop = valid && ready. On pop, rd_ptr increments modulo 2**AW.
- push = load && (!full || pop). On push, mem[wr_ptr] <= D and wr_ptr increments modulo 2**AW.
- count update: count <= count + push - pop. full = (count == 2**AW). valid = (count != 0). Both are decoded from the registered count; there is no combinational path from load or ready.
- Latency: a word loaded at edge N is visible on Q with valid = 1 after edge N. There is no same-cycle bypass from D to Q.
- FWFT: Q = mem[rd_ptr] when valid, else 0.
- Empty + load + ready in the same cycle: the push happens. The pop does not, because valid was 0. The word appears on Q next cycle.
- Full + load + pop in the same cycle: both happen. count stays 2**AW, and the new word goes in the slot freed by the pop.
- Full + load without pop: D is dropped, memory and pointers are unchanged, and overflow <= 1.
- overflow: set has priority over clr_ovf when both occur in the same cycle. Otherwise clr_ovf clears it.
- Pointer wrap: pointers are AW bits and wrap naturally. Full vs empty is disambiguated only by count.
- ready with valid = 0 has no effect. Q and valid must not change except on pop, on push into an empty queue, or on rst.

Optional Feature:
Macro READOUT_STATS_EN.
- Defined: adds output max_count [AW:0], the peak value of count since the last rst or clr_ovf. It updates on the edge after count rises above the stored value, and clr_ovf resets it to the current count.
- Undefined: the port and its register are absent, and all other behaviour is identical.

Test Plan:
- Reset then idle: rst = 1 for 2 cycles, then release → Q = 0, valid = 0, count = 0, full = 0, overflow = 0.
- Fill and drain (W = 16, AW = 2): load 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles with ready = 0 → count = 4, full = 1, Q = 0x1111. Then ready = 1 for 4 cycles → Q sequence 0x1111, 0x2222, 0x3333, 0x4444, then valid = 0 and Q = 0.
- Overflow: with the queue full of 0xA000..0xA003 and ready = 0, load 0xBEEF → overflow = 1, count = 4. Draining yields 0xA000..0xA003 with no 0xBEEF. Asserting clr_ovf → overflow = 0.
- Simultaneous push/pop at full: full, ready = 1, load 0x5555 → count stays 4. 0x5555 emerges as the 4th word after the current head, and overflow stays 0.
- Empty bypass check: empty, load 0x0ABC with ready = 1 → valid = 0 in that cycle. Next cycle valid = 1 and Q = 0x0ABC, and it pops on that edge.
- Reset mid-operation: 3 words queued, rst = 1 with load = 1 and ready = 1 → next cycle count = 0, valid = 0, Q = 0, and the loaded word is discarded. With READOUT_STATS_EN defined, max_count = 0.
